// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_pkg
// Description : Shared constants and helpers for the seven-segment scan
//               driver: blank patterns, digit count, hex segment table and the
//               leading-zero test used when SEVSEG_LZ_BLANK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package sevseg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;   // {g,f,e,d,c,b,a}, active low

  localparam seg_t       SEG_OFF    = 7'h7F;
  localparam logic [7:0] ANODES_OFF = 8'hFF;

  // Entry n holds the active-low pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // True when digit idx is a leading zero: every nibble from idx upward is
  // zero. Digit 0 is never suppressed so a zero value still shows "0".
  function automatic logic lz_blank(input logic [31:0] value, input logic [2:0] idx);
    return (idx != 3'd0) && ((value >> {idx, 2'b00}) == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_sevseg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_sevseg
// Description : Combinational 4-bit nibble to active-low 7-segment decoder.
//   nibble_i  in  4  hex digit
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, active low
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sevseg
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule
`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_scan_driver
// Description : Time-multiplexed 8-digit seven-segment driver. A word loaded
//               on Load_In is held in a shadow register and committed to the
//               display register only at the end of digit 7's slot, so a frame
//               never mixes two values. Each slot starts with BLANK_CYC clocks
//               of all anodes off to avoid ghosting.
//   Clk         in   1   system clock, rising edge
//   Rst         in   1   asynchronous active-high reset
//   Value_In    in   32  word to display, nibble k -> digit k
//   Load_In     in   1   sample Value_In on this edge
//   out7        out  7   segments {g,f,e,d,c,b,a}, active low, registered
//   en_out      out  8   digit anodes, active low, registered
//   Frame_Done  out  1   one-cycle pulse after digit 7's slot ends
// Configuration: define SEVSEG_LZ_BLANK_EN for leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module sevseg_scan_driver #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SLOT_HZ   = 1_000,
  parameter int BLANK_CYC = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Value_In,
  input  logic        Load_In,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        Frame_Done
);

  import sevseg_pkg::*;

  localparam int DIV   = CLK_HZ / SLOT_HZ;
  localparam int CNT_W = $clog2(DIV);

  generate
    if (DIV < 4 || BLANK_CYC >= DIV) begin : g_param_check
      $error("sevseg_scan_driver: need DIV >= 4 and BLANK_CYC < DIV");
    end
  endgenerate

  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      disp_q, disp_d;
  logic [6:0]       out7_q, out7_d;
  logic [7:0]       en_q, en_d;
  logic             fd_q, fd_d;

  logic             w_tick;
  logic             w_commit;
  logic             w_blank;
  logic             w_lz_blank;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;

  assign w_tick   = (count_q == CNT_W'(DIV - 1));
  assign w_commit = w_tick && (idx_q == 3'd7);
  assign w_nibble = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEVSEG_LZ_BLANK_EN
  assign w_lz_blank = lz_blank(disp_q, idx_q);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_blank = (count_q < CNT_W'(BLANK_CYC)) || w_lz_blank;

  hex_to_sevseg u_dec (
    .nibble_i (w_nibble),
    .seg_o    (w_seg)
  );

  always_comb begin
    count_d  = w_tick ? '0 : count_q + 1'b1;
    idx_d    = w_tick ? idx_q + 3'd1 : idx_q;
    shadow_d = Load_In ? Value_In : shadow_q;
    // A load on the commit edge bypasses the shadow so it shows next frame.
    disp_d   = w_commit ? (Load_In ? Value_In : shadow_q) : disp_q;
    fd_d     = w_commit;
    // Outputs lag the slot state by one clock; the commit edge lands on
    // count 0 of digit 0, which is always blank, so no tearing is visible.
    if (w_blank) begin
      en_d   = ANODES_OFF;
      out7_d = SEG_OFF;
    end else begin
      en_d   = ~(8'b1 << idx_q);
      out7_d = w_seg;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q  <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 32'd0;
      disp_q   <= 32'd0;
      out7_q   <= SEG_OFF;
      en_q     <= ANODES_OFF;
      fd_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      out7_q   <= out7_d;
      en_q     <= en_d;
      fd_q     <= fd_d;
    end
  end

  assign out7       = out7_q;
  assign en_out     = en_q;
  assign Frame_Done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevseg_scan_driver
// Description : Self-checking bench for sevseg_scan_driver with DIV=8,
//               BLANK_CYC=2. Each table row describes one whole frame: the
//               expected segment pattern per digit, the digits lit under
//               leading-zero suppression, and loads issued during the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevseg_scan_driver;

  logic        Clk;
  logic        Rst;
  logic [31:0] Value_In;
  logic        Load_In;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        Frame_Done;

  int checks = 0;
  int errors = 0;

  sevseg_scan_driver #(
    .CLK_HZ    (800),
    .SLOT_HZ   (100),
    .BLANK_CYC (2)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Value_In   (Value_In),
    .Load_In    (Load_In),
    .out7       (out7),
    .en_out     (en_out),
    .Frame_Done (Frame_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Anode sanity and anti-ghost blanking, watched on every falling edge.
  logic [7:0] last_lit = 8'hFF;
  int         blank_run = 0;
  always @(negedge Clk) begin
    checks++;
    if ($countones(~en_out) > 1) begin
      errors++;
      $display("FAIL onehot: en_out=%h", en_out);
    end
    if (en_out == 8'hFF) begin
      blank_run++;
    end else begin
      if (en_out != last_lit && blank_run < 2) begin
        errors++;
        $display("FAIL ghost: en_out %h after %h with %0d blank cycles", en_out, last_lit, blank_run);
      end
      last_lit  = en_out;
      blank_run = 0;
    end
  end

  typedef struct {
    logic [7:0][6:0] seg;      // expected pattern per digit
    logic [7:0]      lz_mask;  // digits lit with leading-zero suppression
    int              decoy_m;  // frame sample after which a decoy load is issued
    logic [31:0]     decoy_v;
    int              load_m;   // frame sample after which the real load is issued
    logic [31:0]     load_v;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] mask;
    logic [7:0] exp_en;
    logic [6:0] exp_seg;
    int s, k, j;

    // Frame after reset: value 0, load 0x01234567 mid-frame.
    vecs[0] = '{{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'h01, 0, 32'h0, 30, 32'h0123_4567};
    // 0x01234567: decoy load then DEADBEEF later in the same frame.
    vecs[1] = '{{7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78}, 8'h7F, 20, 32'h1111_1111, 40, 32'hDEAD_BEEF};
    // 0xDEADBEEF: load all-F exactly on the commit cycle.
    vecs[2] = '{{7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E}, 8'hFF, 0, 32'h0, 63, 32'hFFFF_FFFF};
    vecs[3] = '{{7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E}, 8'hFF, 0, 32'h0, 20, 32'h0000_00A5};
    vecs[4] = '{{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h08,7'h12}, 8'h03, 0, 32'h0, 50, 32'h0};
    vecs[5] = '{{7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'h01, 0, 32'h0, 0, 32'h0};

    Rst      = 1'b1;
    Load_In  = 1'b0;
    Value_In = 32'h0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_out7", {25'd0, out7}, 32'h7F);
    check("reset_en", {24'd0, en_out}, 32'hFF);
    check("reset_fd", {31'd0, Frame_Done}, 32'h0);
    Rst = 1'b0;

    // 20 samples after release: digit 2, count 3 is lit.
    repeat (20) @(posedge Clk);
    #1;
    check("prerst_en", {24'd0, en_out}, 32'hFB);
    check("prerst_out7", {25'd0, out7}, 32'h40);

    // Reset mid-slot takes effect immediately, without a clock edge.
    #2 Rst = 1'b1;
    #1;
    check("midrst_out7", {25'd0, out7}, 32'h7F);
    check("midrst_en", {24'd0, en_out}, 32'hFF);
    check("midrst_fd", {31'd0, Frame_Done}, 32'h0);
    @(posedge Clk);
    #1 Rst = 1'b0;

    // Sample m of a frame reflects slot state m-1: slot k = (m-1)/8,
    // count j = (m-1)%8. Sample 64 is the next frame's Frame_Done cycle.
    for (int v = 0; v < 6; v++) begin
`ifdef SEVSEG_LZ_BLANK_EN
      mask = vecs[v].lz_mask;
`else
      mask = 8'hFF;
`endif
      for (int m = 1; m <= 64; m++) begin
        @(posedge Clk);
        #1;
        s = m - 1;
        k = s / 8;
        j = s % 8;
        if (j >= 2 && mask[k]) begin
          exp_en  = ~(8'b1 << k);
          exp_seg = vecs[v].seg[k];
        end else begin
          exp_en  = 8'hFF;
          exp_seg = 7'h7F;
        end
        check($sformatf("f%0d_en_s%0d", v, m), {24'd0, en_out}, {24'd0, exp_en});
        check($sformatf("f%0d_seg_s%0d", v, m), {25'd0, out7}, {25'd0, exp_seg});
        check($sformatf("f%0d_fd_s%0d", v, m), {31'd0, Frame_Done}, {31'd0, (m == 64)});
        if (m == vecs[v].decoy_m) begin
          Load_In  = 1'b1;
          Value_In = vecs[v].decoy_v;
        end else if (m == vecs[v].load_m) begin
          Load_In  = 1'b1;
          Value_In = vecs[v].load_v;
        end else begin
          Load_In  = 1'b0;
          Value_In = 32'h5A5A_5A5A;  // ignored without a load strobe
        end
      end
    end

    Load_In = 1'b0;
    repeat (4) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
